ultrasonic_burst_tx: RTL and testbench

Transmit-side counterpart to the Doppler/echo receive chain. On a trigger it drives a fixed-frequency square-wave burst (default 40 kHz, the same emitted frequency the receive chain assumes) on a complementary transducer driver pair. It then holds a receiver blanking window, and marks the time-of-flight origin with a one-cycle strobe. It sits between the top-level ranging controller (trigger/abort) and the transducer driver pins.

---
 rtl/ultrasonic_burst_tx.sv | 125 ++++++++++++
 tb/tb_ultrasonic_burst_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_burst_tx.sv
// Purpose: on trigger, drives a complementary square-wave burst, then holds a receiver blanking window.
// Latency: drive starts 1 cycle after the trigger is sampled; burst_done_out strobes in the first cycle after the burst.
// Backpressure: none; triggers while busy are dropped, and abort_in returns the block to IDLE on the next edge.
module ultrasonic_burst_tx #(
    parameter int CLK_FREQ          = 100_000_000,
    parameter int EMITTED_FREQUENCY = 40000,
    parameter int BLANK_CYCLES      = 20000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       trigger_in,
    input  logic [7:0] burst_len_in,
    input  logic       abort_in,
    output logic       tx_out,
    output logic       tx_n_out,
    output logic       busy_out,
    output logic       blank_out,
    output logic       burst_done_out
);

    // HALF_PERIOD must be at least 1 for the chosen clock and tone frequencies.
    localparam int HALF_PERIOD = CLK_FREQ / (2 * EMITTED_FREQUENCY);
    localparam int CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BLK_W       = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam int BLK_LAST_I  = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLK_LAST_I);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [8:0]         half_q, half_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic               phase_q, phase_d;
    logic               done_q, done_d;

    // State and datapath registers; reset clears everything so outputs drop at once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            len_q   <= 8'd0;
            cnt_q   <= '0;
            half_q  <= 9'd0;
            blk_q   <= '0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    // Next-state and counter update; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        blk_d   = blk_q;
        phase_d = phase_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (trigger_in && !abort_in && (burst_len_in != 8'd0)) begin
                    state_d = BURST;
                    len_d   = burst_len_in;
                    cnt_d   = '0;
                    half_d  = 9'd0;
                    blk_d   = '0;
                    phase_d = 1'b1;
                end
            end
            BURST: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else if (cnt_q == HP_LAST) begin
                    cnt_d = '0;
                    // The final low half ends the tone; the strobe marks time-of-flight zero.
                    if ((half_q + 9'd1) == {len_q, 1'b0}) begin
                        state_d = (BLANK_CYCLES == 0) ? IDLE : BLANK;
                        blk_d   = '0;
                        phase_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = ~phase_q;
                        half_d  = half_q + 9'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BLANK: begin
                if (abort_in || (blk_q == BLK_LAST)) begin
                    state_d = IDLE;
                end else begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset forces them low asynchronously.
    assign tx_out         = (state_q == BURST) &  phase_q;
    assign tx_n_out       = (state_q == BURST) & ~phase_q;
    assign busy_out       = (state_q != IDLE);
    assign blank_out      = (state_q == BURST) || (state_q == BLANK);
    assign burst_done_out = done_q;

endmodule

// File: tb/tb_ultrasonic_burst_tx.sv
module tb_ultrasonic_burst_tx;

    localparam int HP = 4;

    typedef struct {
        int         stamp;
        logic [4:0] v;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       trig0, abort0, trig1, abort1;
    logic [7:0] len0, len1;
    logic       tx0, txn0, busy0, blank0, done0;
    logic       tx1, txn1, busy1, blank1, done1;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   t, t2, c;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    ultrasonic_burst_tx #(
        .CLK_FREQ(800), .EMITTED_FREQUENCY(100), .BLANK_CYCLES(6)
    ) u0 (
        .clk_in(clk), .rst_in(rst), .trigger_in(trig0), .burst_len_in(len0),
        .abort_in(abort0), .tx_out(tx0), .tx_n_out(txn0), .busy_out(busy0),
        .blank_out(blank0), .burst_done_out(done0)
    );

    ultrasonic_burst_tx #(
        .CLK_FREQ(800), .EMITTED_FREQUENCY(100), .BLANK_CYCLES(0)
    ) u1 (
        .clk_in(clk), .rst_in(rst), .trigger_in(trig1), .burst_len_in(len1),
        .abort_in(abort1), .tx_out(tx1), .tx_n_out(txn1), .busy_out(busy1),
        .blank_out(blank1), .burst_done_out(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output vector {tx, tx_n, busy, blank, done} for one cycle of one DUT.
    task automatic push(input int d, input int s, input logic [4:0] v);
        exp_t e;
        e.stamp = s;
        e.v     = v;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Burst waveform starting at cycle t0; cut>=0 models an abort/reset after 'cut' burst cycles.
    task automatic push_seq(input int d, input int t0, input int len, input int blank,
                            input int cut, input int tail);
        int   n;
        logic tx;
        n = 2 * len * HP;
        if (cut >= 0) begin
            for (int i = 0; i < cut; i++) begin
                tx = ((i / HP) % 2) == 0;
                push(d, t0 + i, {tx, ~tx, 3'b110});
            end
            push(d, t0 + cut, 5'b00000);
        end else begin
            for (int i = 0; i < n; i++) begin
                tx = ((i / HP) % 2) == 0;
                push(d, t0 + i, {tx, ~tx, 3'b110});
            end
            for (int j = 0; j < blank; j++)
                push(d, t0 + n + j, {4'b0011, (j == 0)});
            for (int k = 0; k < tail; k++)
                push(d, t0 + n + blank + k, {4'b0000, (k == 0) && (blank == 0)});
        end
    endtask

    task automatic check_now(input string name, input logic [4:0] act, input logic [4:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got=%b required=%b", name, act, req);
        end
    endtask

    task automatic fire(input int d, input logic [7:0] l, output int ts);
        @(posedge clk); #1;
        if (d == 0) begin trig0 = 1'b1; len0 = l; end
        else        begin trig1 = 1'b1; len1 = l; end
        ts = cyc + 1;
        @(posedge clk); #1;
        trig0 = 1'b0;
        trig1 = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 400) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 400) begin
            n_bad++;
            $display("FAIL %s_timeout pending=%0d/%0d required=0/0", name, q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    // Monitor: pops expected vectors as their cycle comes up and compares against the DUT.
    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].stamp < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL dut0_missed stamp=%0d now=%0d", q0[0].stamp, cyc);
            void'(q0.pop_front());
        end
        if (q0.size() > 0 && q0[0].stamp == cyc) begin
            e0 = q0.pop_front();
            n_cmp++;
            if ({tx0, txn0, busy0, blank0, done0} !== e0.v) begin
                n_bad++;
                $display("FAIL dut0_vec cyc=%0d got=%b required=%b",
                         cyc, {tx0, txn0, busy0, blank0, done0}, e0.v);
            end
        end
        while (q1.size() > 0 && q1[0].stamp < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL dut1_missed stamp=%0d now=%0d", q1[0].stamp, cyc);
            void'(q1.pop_front());
        end
        if (q1.size() > 0 && q1[0].stamp == cyc) begin
            e1 = q1.pop_front();
            n_cmp++;
            if ({tx1, txn1, busy1, blank1, done1} !== e1.v) begin
                n_bad++;
                $display("FAIL dut1_vec cyc=%0d got=%b required=%b",
                         cyc, {tx1, txn1, busy1, blank1, done1}, e1.v);
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1;
        trig0 = 1'b0; abort0 = 1'b0; len0 = 8'd0;
        trig1 = 1'b0; abort1 = 1'b0; len1 = 8'd0;
        #1;
        check_now("reset_dut0", {tx0, txn0, busy0, blank0, done0}, 5'b00000);
        check_now("reset_dut1", {tx1, txn1, busy1, blank1, done1}, 5'b00000);
        repeat (2) @(posedge clk);
        #7 rst = 1'b0;

        // len=2: 1111 0000 1111 0000, done at cycle 17, blank high 22 cycles.
        fire(0, 8'd2, t);
        push_seq(0, t, 2, 6, -1, 2);
        wait_empty("len2");

        // len=0 trigger is ignored.
        @(posedge clk); #1;
        trig0 = 1'b1; len0 = 8'd0; c = cyc;
        for (int i = 1; i <= 6; i++) push(0, c + i, 5'b00000);
        @(posedge clk); #1;
        trig0 = 1'b0;
        wait_empty("len0");

        // Trigger together with abort in IDLE: abort wins.
        @(posedge clk); #1;
        trig0 = 1'b1; abort0 = 1'b1; len0 = 8'd2; c = cyc;
        for (int i = 1; i <= 4; i++) push(0, c + i, 5'b00000);
        @(posedge clk); #1;
        trig0 = 1'b0; abort0 = 1'b0;
        wait_empty("trig_abort_idle");

        // len=3 with retrigger at cycle 5 and length change: burst stays 24 cycles.
        fire(0, 8'd3, t);
        push_seq(0, t, 3, 6, -1, 2);
        repeat (4) @(posedge clk);
        #1;
        trig0 = 1'b1; len0 = 8'd7;
        @(posedge clk); #1;
        trig0 = 1'b0;
        wait_empty("retrigger");
        len0 = 8'd0;

        // Abort during cycle 10 of a len=2 burst, retrigger in first IDLE cycle.
        fire(0, 8'd2, t);
        push_seq(0, t, 2, 6, 10, 0);
        repeat (9) @(posedge clk);
        #1;
        abort0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0;
        trig0 = 1'b1; len0 = 8'd1;
        t2 = cyc + 1;
        push_seq(0, t2, 1, 6, -1, 2);
        @(posedge clk); #1;
        trig0 = 1'b0;
        wait_empty("abort");

        // No blanking: done coincides with busy falling, 8 cycles of drive.
        fire(1, 8'd1, t);
        push_seq(1, t, 1, 0, -1, 3);
        wait_empty("blank0");

        // Asynchronous reset mid-burst while tx_out is high.
        fire(0, 8'd2, t);
        push_seq(0, t, 2, 6, 3, 0);
        repeat (2) @(posedge clk);
        #7;
        rst = 1'b1;
        #1;
        check_now("async_reset", {tx0, txn0, busy0, blank0, done0}, 5'b00000);
        @(posedge clk);
        @(posedge clk);
        #7 rst = 1'b0;
        c = cyc;
        for (int i = 1; i <= 5; i++) push(0, c + i, 5'b00000);
        wait_empty("post_reset_idle");

        fire(0, 8'd1, t);
        push_seq(0, t, 1, 6, -1, 2);
        wait_empty("post_reset_burst");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
